// File: rtl/cp0_unit_pkg.sv
// cp0_defs: shared definitions for the CP0 coprocessor.
//   - CP0 register addresses used by MFC0/MTC0.
//   - Bit positions of the Status and Cause fields.
//   - Packed Status type and helpers that build the architectural read words.
package cp0_defs;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_EBASE   = 5'd15;

    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LSB = 8;
    localparam int STATUS_IM_MSB = 15;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_EXC_MSB = 6;
    localparam int CAUSE_IP_LSB  = 8;
    localparam int CAUSE_IP_MSB  = 15;

    localparam logic [4:0] EXC_INT = 5'd0;

    typedef struct packed {
        logic [7:0] im;
        logic       exl;
        logic       ie;
    } status_t;

    // Status as seen by MFC0: unimplemented bits read 0.
    function automatic logic [31:0] status_word(input status_t s);
        logic [31:0] w;
        w = '0;
        w[STATUS_IE]                   = s.ie;
        w[STATUS_EXL]                  = s.exl;
        w[STATUS_IM_MSB:STATUS_IM_LSB] = s.im;
        return w;
    endfunction

    // Cause as seen by MFC0 (and, with ExcCode=Int, as hw_cause).
    function automatic logic [31:0] cause_word(input logic [7:0] ip, input logic [4:0] exc);
        logic [31:0] w;
        w = '0;
        w[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = exc;
        w[CAUSE_IP_MSB:CAUSE_IP_LSB]   = ip;
        return w;
    endfunction

endpackage

// File: rtl/cp0_unit_timer.sv
// cp0_timer: Count/Compare timer for CP0.
//   clk, rst          : clock, asynchronous active-low reset
//   count_we          : load Count with wdata instead of incrementing
//   compare_we        : load Compare with wdata and clear the pending bit
//   wdata             : MTC0 write data
//   count, compare    : current register values
//   timer_irq         : sticky pending bit, set the edge after Count == Compare
module cp0_timer
    import cp0_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_irq
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        pending_q, pending_d;

    // NOTE: every variable assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d   = count_we ? wdata : count_q + 32'd1;
        compare_d = compare_we ? wdata : compare_q;
        pending_d = pending_q;
        // A Compare write on the matching cycle must win over the set.
        if (compare_we) begin
            pending_d = 1'b0;
        end else if (count_q == compare_q) begin
            pending_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= '0;
            compare_q <= 32'hFFFF_FFFF;
            pending_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            pending_q <= pending_d;
        end
    end

    assign count     = count_q;
    assign compare   = compare_q;
    assign timer_irq = pending_q;

endmodule

// File: rtl/cp0_unit.sv
// cp0_unit: system coprocessor 0 downstream of the core.
//   clk, rst                 : clock, asynchronous active-low reset
//   exception, cause, epc    : exception taken this cycle, its cause word and faulting PC
//   eret                     : return from exception (clears EXL)
//   cp0_addr_o/data_o/we_o   : MFC0/MTC0 access from the core
//   irq_i                    : asynchronous external interrupt levels
//   cp0_data_i               : combinational MFC0 read data
//   cp0_exception_base       : current EBase
//   hw_interrupt, hw_cause   : registered interrupt request and its cause word
module cp0_unit
    import cp0_defs::*;
#(
    parameter logic [31:0] RESET_EBASE = 32'hFFFF_FFF0,
    parameter int          N_IRQ       = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exception,
    input  logic [31:0]      cause,
    input  logic [31:0]      epc,
    input  logic             eret,
    input  logic [4:0]       cp0_addr_o,
    input  logic [31:0]      cp0_data_o,
    input  logic             cp0_we_o,
    input  logic [N_IRQ-1:0] irq_i,
    output logic [31:0]      cp0_data_i,
    output logic [31:0]      cp0_exception_base,
    output logic             hw_interrupt,
    output logic [31:0]      hw_cause
);

    // Only six hardware IP bits exist; extra lines beyond that are dropped.
    localparam int N_HW = (N_IRQ < 6) ? N_IRQ : 6;

    status_t          status_q, status_d;
    logic [4:0]       exc_code_q, exc_code_d;
    logic [1:0]       sw_ip_q, sw_ip_d;
    logic [31:0]      epc_q, epc_d;
    logic [31:2]      ebase_q, ebase_d;
    logic [N_IRQ-1:0] irq_meta_q, irq_meta_d;
    logic [N_IRQ-1:0] irq_sync_q, irq_sync_d;
    logic             hw_interrupt_q, hw_interrupt_d;
    logic [31:0]      hw_cause_q, hw_cause_d;

    logic [7:0]  ip;
    logic [31:0] count, compare;
    logic        timer_irq;
    logic        unused_cause_bits;

    assign unused_cause_bits = ^{cause[31:7], cause[1:0]};

    cp0_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (cp0_we_o && cp0_addr_o == CP0_COUNT),
        .compare_we (cp0_we_o && cp0_addr_o == CP0_COMPARE),
        .wdata      (cp0_data_o),
        .count      (count),
        .compare    (compare),
        .timer_irq  (timer_irq)
    );

    // Pending bits: IP[1:0] software, IP[7:2] synchronised lines; the timer shares IP7.
    always_comb begin
        ip                = '0;
        ip[1:0]           = sw_ip_q;
        ip[N_HW+1:2]      = irq_sync_q[N_HW-1:0];
        ip[7]             = ip[7] | timer_irq;
    end

    always_comb begin
        status_d   = status_q;
        exc_code_d = exc_code_q;
        sw_ip_d    = sw_ip_q;
        epc_d      = epc_q;
        ebase_d    = ebase_q;
        irq_meta_d = irq_i;
        irq_sync_d = irq_meta_q;

        if (cp0_we_o) begin
            case (cp0_addr_o)
                CP0_STATUS: begin
                    status_d.ie  = cp0_data_o[STATUS_IE];
                    status_d.exl = cp0_data_o[STATUS_EXL];
                    status_d.im  = cp0_data_o[STATUS_IM_MSB:STATUS_IM_LSB];
                end
                CP0_CAUSE: sw_ip_d = cp0_data_o[CAUSE_IP_LSB+1:CAUSE_IP_LSB];
                CP0_EPC:   epc_d   = cp0_data_o;
                CP0_EBASE: ebase_d = cp0_data_o[31:2];
                default:   ;
            endcase
        end

        // Later assignments override earlier ones: exception > eret > MTC0.
        if (eret) begin
            status_d.exl = 1'b0;
        end
        if (exception) begin
            exc_code_d   = cause[CAUSE_EXC_MSB:CAUSE_EXC_LSB];
            epc_d        = status_q.exl ? epc_q : epc;
            status_d.exl = 1'b1;
        end

        hw_interrupt_d = status_q.ie & ~status_q.exl & (|(ip & status_q.im));
        hw_cause_d     = cause_word(ip, EXC_INT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_q       <= '0;
            exc_code_q     <= '0;
            sw_ip_q        <= '0;
            epc_q          <= '0;
            ebase_q        <= RESET_EBASE[31:2];
            irq_meta_q     <= '0;
            irq_sync_q     <= '0;
            hw_interrupt_q <= 1'b0;
            hw_cause_q     <= '0;
        end else begin
            status_q       <= status_d;
            exc_code_q     <= exc_code_d;
            sw_ip_q        <= sw_ip_d;
            epc_q          <= epc_d;
            ebase_q        <= ebase_d;
            irq_meta_q     <= irq_meta_d;
            irq_sync_q     <= irq_sync_d;
            hw_interrupt_q <= hw_interrupt_d;
            hw_cause_q     <= hw_cause_d;
        end
    end

    // MFC0 read path: pre-edge state, so a same-cycle write is not visible yet.
    always_comb begin
        cp0_data_i = '0;
        case (cp0_addr_o)
            CP0_COUNT:   cp0_data_i = count;
            CP0_COMPARE: cp0_data_i = compare;
            CP0_STATUS:  cp0_data_i = status_word(status_q);
            CP0_CAUSE:   cp0_data_i = cause_word(ip, exc_code_q);
            CP0_EPC:     cp0_data_i = epc_q;
            CP0_EBASE:   cp0_data_i = {ebase_q, 2'b00};
            default:     cp0_data_i = '0;
        endcase
    end

    assign cp0_exception_base = {ebase_q, 2'b00};
    assign hw_interrupt       = hw_interrupt_q;
    assign hw_cause           = hw_cause_q;

endmodule

// File: tb/tb_cp0_unit.sv
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        exception;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        eret;
    logic [4:0]  cp0_addr_o;
    logic [31:0] cp0_data_o;
    logic        cp0_we_o;
    logic [5:0]  irq_i;
    logic [31:0] cp0_data_i;
    logic [31:0] cp0_exception_base;
    logic        hw_interrupt;
    logic [31:0] hw_cause;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] got;
    int          n_pass  = 0;
    int          n_total = 0;

    cp0_unit #(.RESET_EBASE(32'hFFFF_FFF0), .N_IRQ(6)) dut (
        .clk                (clk),
        .rst                (rst),
        .exception          (exception),
        .cause              (cause),
        .epc                (epc),
        .eret               (eret),
        .cp0_addr_o         (cp0_addr_o),
        .cp0_data_o         (cp0_data_o),
        .cp0_we_o           (cp0_we_o),
        .irq_i              (irq_i),
        .cp0_data_i         (cp0_data_i),
        .cp0_exception_base (cp0_exception_base),
        .hw_interrupt       (hw_interrupt),
        .hw_cause           (hw_cause)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_we_o   = 1'b1;
        cp0_addr_o = a;
        cp0_data_o = d;
        tick();
        cp0_we_o   = 1'b0;
    endtask

    task automatic mfc0(input logic [4:0] a, output logic [31:0] v);
        cp0_addr_o = a;
        @(negedge clk);
        v = cp0_data_i;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        sb.push_back('{"rst_base_during", 32'hFFFF_FFF0});
        sb.push_back('{"rst_hwint_during", 32'd0});
        got = cp0_exception_base; e = sb.pop_front(); n_total++;
        if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        got = {31'd0, hw_interrupt}; e = sb.pop_front(); n_total++;
        if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        rst = 1'b1;
        tick();
        sb.push_back('{"rst_status", 32'd0});
        sb.push_back('{"rst_compare", 32'hFFFF_FFFF});
        sb.push_back('{"rst_hw_cause", 32'd0});
        mfc0(5'd12, got); e = sb.pop_front(); n_total++;
        if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        mfc0(5'd11, got); e = sb.pop_front(); n_total++;
        if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        got = hw_cause; e = sb.pop_front(); n_total++;
        if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
    endtask

    task automatic test_exception();
        exception = 1'b1; epc = 32'h40; cause = 32'h30;
        tick();
        exception = 1'b0;
        sb.push_back('{"exc_epc", 32'h40});
        sb.push_back('{"exc_cause", 32'h30});
        sb.push_back('{"exc_status_exl", 32'h2});
        mfc0(5'd14, got); e = sb.pop_front(); n_total++;
        if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        mfc0(5'd13, got); e = sb.pop_front(); n_total++;
        if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        mfc0(5'd12, got); e = sb.pop_front(); n_total++;
        if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        // Nested exception keeps the first EPC.
        exception = 1'b1; epc = 32'h80;
        tick();
        exception = 1'b0;
        sb.push_back('{"nested_epc", 32'h40});
        mfc0(5'd14, got); e = sb.pop_front(); n_total++;
        if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        eret = 1'b1;
        tick();
        eret = 1'b0;
        sb.push_back('{"eret_status", 32'h0});
        mfc0(5'd12, got); e = sb.pop_front(); n_total++;
        if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
    endtask

    task automatic test_irq();
        mtc0(5'd12, 32'h0000_0401);
        irq_i = 6'b000001;
        // Sampled in the cycle of the request, then after each of the next three edges.
        for (int c = 0; c < 4; c++) sb.push_back('{$sformatf("irq_lat_c%0d", c), (c == 3) ? 32'd1 : 32'd0});
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            got = {31'd0, hw_interrupt}; e = sb.pop_front(); n_total++;
            if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        end
        sb.push_back('{"irq_hw_cause", 32'h0000_0400});
        got = hw_cause; e = sb.pop_front(); n_total++;
        if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        sb.push_back('{"irq_cause_read", 32'h0000_0430});
        mfc0(5'd13, got); e = sb.pop_front(); n_total++;
        if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        // Mask IM2: request drops one edge after the Status write lands.
        mtc0(5'd12, 32'h0000_0001);
        sb.push_back('{"im_clr_edge0", 32'd1});
        sb.push_back('{"im_clr_edge1", 32'd0});
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            got = {31'd0, hw_interrupt}; e = sb.pop_front(); n_total++;
            if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        end
        mtc0(5'd12, 32'h0000_0401);
        repeat (2) @(negedge clk);
        // Taking the exception sets EXL and the request deasserts on the following edge.
        exception = 1'b1; epc = 32'h100; cause = 32'h0;
        tick();
        exception = 1'b0;
        sb.push_back('{"exl_edge0", 32'd1});
        sb.push_back('{"exl_edge1", 32'd0});
        sb.push_back('{"exl_edge2", 32'd0});
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            got = {31'd0, hw_interrupt}; e = sb.pop_front(); n_total++;
            if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        irq_i = '0;
        mtc0(5'd12, 32'h0);
        repeat (3) tick();
    endtask

    task automatic test_timer();
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd9, 32'd0);
        mtc0(5'd11, 32'd10);
        cp0_addr_o = 5'd9;
        for (int k = 1; k <= 14; k++) begin
            sb.push_back('{$sformatf("count_k%0d", k), 32'(k)});
            sb.push_back('{$sformatf("timer_hw_k%0d", k), (k >= 12) ? 32'd1 : 32'd0});
        end
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            got = cp0_data_i; e = sb.pop_front(); n_total++;
            if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
            got = {31'd0, hw_interrupt}; e = sb.pop_front(); n_total++;
            if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        end
        sb.push_back('{"timer_hw_cause", 32'h0000_8000});
        got = hw_cause; e = sb.pop_front(); n_total++;
        if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        // Compare write clears the pending bit.
        mtc0(5'd11, 32'd100);
        sb.push_back('{"cmp_clr_cause", 32'h0});
        sb.push_back('{"cmp_clr_hw", 32'd0});
        mfc0(5'd13, got); e = sb.pop_front(); n_total++;
        if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        @(negedge clk);
        got = {31'd0, hw_interrupt}; e = sb.pop_front(); n_total++;
        if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        // Compare written on the very cycle Count matches: clear wins.
        mtc0(5'd9, 32'd98);
        tick();
        tick();
        mtc0(5'd11, 32'd200);
        sb.push_back('{"clear_wins_cause", 32'h0});
        sb.push_back('{"clear_wins_hw", 32'd0});
        mfc0(5'd13, got); e = sb.pop_front(); n_total++;
        if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        @(negedge clk);
        got = {31'd0, hw_interrupt}; e = sb.pop_front(); n_total++;
        if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        // Wrap.
        mtc0(5'd9, 32'hFFFF_FFFF);
        sb.push_back('{"wrap_max", 32'hFFFF_FFFF});
        sb.push_back('{"wrap_zero", 32'h0});
        sb.push_back('{"wrap_one", 32'h1});
        for (int c = 0; c < 3; c++) begin
            mfc0(5'd9, got); e = sb.pop_front(); n_total++;
            if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        end
        mtc0(5'd11, 32'hFFFF_FFFF);
    endtask

    task automatic test_priority();
        mtc0(5'd12, 32'h0000_0001);
        exception  = 1'b1; eret = 1'b1; cause = 32'h24; epc = 32'hC0;
        cp0_we_o   = 1'b1; cp0_addr_o = 5'd12; cp0_data_o = 32'h0;
        tick();
        exception  = 1'b0; eret = 1'b0; cp0_we_o = 1'b0;
        sb.push_back('{"prio_status", 32'h2});
        sb.push_back('{"prio_epc", 32'hC0});
        sb.push_back('{"prio_cause", 32'h24});
        mfc0(5'd12, got); e = sb.pop_front(); n_total++;
        if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        mfc0(5'd14, got); e = sb.pop_front(); n_total++;
        if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        mfc0(5'd13, got); e = sb.pop_front(); n_total++;
        if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
    endtask

    task automatic test_regs();
        // Read during the write cycle returns the old EBase.
        cp0_we_o = 1'b1; cp0_addr_o = 5'd15; cp0_data_o = 32'h8000_0100;
        #1;
        sb.push_back('{"ebase_old_read", 32'hFFFF_FFF0});
        got = cp0_data_i; e = sb.pop_front(); n_total++;
        if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        tick();
        cp0_we_o = 1'b0;
        sb.push_back('{"ebase_out", 32'h8000_0100});
        @(negedge clk);
        got = cp0_exception_base; e = sb.pop_front(); n_total++;
        if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        mtc0(5'd15, 32'h8000_0207);
        sb.push_back('{"ebase_low_bits", 32'h8000_0204});
        mfc0(5'd15, got); e = sb.pop_front(); n_total++;
        if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        mtc0(5'd5, 32'hDEAD_BEEF);
        sb.push_back('{"unmapped_read", 32'h0});
        mfc0(5'd5, got); e = sb.pop_front(); n_total++;
        if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        // Only software IP bits are writable in Cause.
        mtc0(5'd13, 32'hFFFF_FFFF);
        sb.push_back('{"cause_sw_only", 32'h0000_0324});
        mfc0(5'd13, got); e = sb.pop_front(); n_total++;
        if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
    endtask

    task automatic test_reset_mid();
        mtc0(5'd11, 32'd20);
        mtc0(5'd9, 32'd20);
        tick();
        sb.push_back('{"pre_rst_cause", 32'h0000_8324});
        mfc0(5'd13, got); e = sb.pop_front(); n_total++;
        if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        #2;
        rst = 1'b0;
        sb.push_back('{"mid_rst_cause", 32'h0});
        sb.push_back('{"mid_rst_status", 32'h0});
        sb.push_back('{"mid_rst_compare", 32'hFFFF_FFFF});
        sb.push_back('{"mid_rst_base", 32'hFFFF_FFF0});
        sb.push_back('{"mid_rst_hw", 32'd0});
        #1;
        got = cp0_data_i; e = sb.pop_front(); n_total++;
        if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        cp0_addr_o = 5'd12;
        #1;
        got = cp0_data_i; e = sb.pop_front(); n_total++;
        if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        cp0_addr_o = 5'd11;
        #1;
        got = cp0_data_i; e = sb.pop_front(); n_total++;
        if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        got = cp0_exception_base; e = sb.pop_front(); n_total++;
        if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        got = {31'd0, hw_interrupt}; e = sb.pop_front(); n_total++;
        if (got !== e.val) $display("FAIL %s: got %h want %h", e.name, got, e.val); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    initial begin
        rst        = 1'b0;
        exception  = 1'b0;
        cause      = '0;
        epc        = '0;
        eret       = 1'b0;
        cp0_addr_o = '0;
        cp0_data_o = '0;
        cp0_we_o   = 1'b0;
        irq_i      = '0;
        test_reset();
        test_exception();
        test_irq();
        test_timer();
        test_priority();
        test_regs();
        test_reset_mid();
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
